// File: rtl/device_arb_pkg.sv
// device_arb_pkg: state encoding, default widths and mask-width helper shared by the device arbiter.
package device_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    function automatic int mask_w(input int data_w);
        return data_w / 8;
    endfunction
endpackage

// File: rtl/device_rr_picker.sv
// device_rr_picker: combinational rotating-priority pick starting the scan at ptr.
module device_rr_picker
    import device_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_valid
);
    function automatic logic [IW-1:0] wrap(input int s);
        return IW'(s >= N ? s - N : s);
    endfunction
    // Scan from the farthest offset down so the closest valid requester to ptr wins.
    always_comb begin
        grant = '0;
        idx = '0;
        any_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[wrap(int'(ptr) + i)]) begin
                grant = '0;
                grant[wrap(int'(ptr) + i)] = 1'b1;
                idx = wrap(int'(ptr) + i);
                any_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/device_req_arbiter.sv
// device_req_arbiter: shares one device port among NUM_REQ requesters, one transaction at a time.
// Define DEVICE_ARB_FIXED_PRIO_EN for lowest-index-wins instead of round-robin.
module device_req_arbiter
    import device_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_wen,
    input  logic [NUM_REQ*ADDR_W-1:0]       req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]       req_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0]   req_wmask,
    output logic [NUM_REQ-1:0]              resp_valid,
    input  logic [NUM_REQ-1:0]              resp_ready,
    output logic [DATA_W-1:0]               resp_rdata,
    output logic                            dev_req_valid,
    output logic                            dev_req_wen,
    output logic [ADDR_W-1:0]               dev_req_addr,
    output logic [DATA_W-1:0]               dev_req_wdata,
    output logic [DATA_W/8-1:0]             dev_req_wmask,
    input  logic [DATA_W-1:0]               dev_resp_rdata
);
    localparam int MW = mask_w(DATA_W);
    localparam int IW = $clog2(NUM_REQ);
    state_t state;
    logic [IW-1:0] rr_ptr, owner, pick_ptr, next_ptr, grant_idx;
    logic [NUM_REQ-1:0] grant;
    logic any_valid;
    logic wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [MW-1:0] wmask_q;
`ifdef DEVICE_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
    assign next_ptr = '0;
`else
    assign pick_ptr = rr_ptr;
    assign next_ptr = owner == IW'(NUM_REQ - 1) ? '0 : owner + 1'b1;
`endif
    device_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
        .req(req_valid),
        .ptr(pick_ptr),
        .grant(grant),
        .idx(grant_idx),
        .any_valid(any_valid)
    );
    assign req_ready = (state == IDLE && !reset) ? grant : '0;
    assign resp_valid = state == RESP ? NUM_REQ'(1) << owner : '0;
    assign resp_rdata = rdata_q;
    assign dev_req_valid = state == ISSUE;
    assign dev_req_wen = wen_q;
    assign dev_req_addr = addr_q;
    assign dev_req_wdata = wdata_q;
    assign dev_req_wmask = wmask_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
            wen_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (any_valid) begin
                    wen_q <= req_wen[grant_idx];
                    addr_q <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                    wdata_q <= req_wdata[grant_idx*DATA_W +: DATA_W];
                    wmask_q <= req_wmask[grant_idx*MW +: MW];
                    owner <= grant_idx;
                    state <= ISSUE;
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    rdata_q <= wen_q ? '0 : dev_resp_rdata;
                    state <= RESP;
                end
                RESP: if (resp_ready[owner]) begin
                    rr_ptr <= next_ptr;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_device_req_arbiter.sv
// tb_device_req_arbiter: directed vectors against device_req_arbiter with a simple device model.
module tb_device_req_arbiter;
    localparam int N = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_valid, req_ready, req_wen, resp_valid, resp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*MW-1:0] req_wmask;
    logic [DW-1:0] resp_rdata, dev_req_wdata, dev_val;
    logic [DW-1:0] dev_resp_rdata = '0;
    logic dev_req_valid, dev_req_wen;
    logic [AW-1:0] dev_req_addr;
    logic [MW-1:0] dev_req_wmask;
    int total = 0;
    int bad = 0;
    always #5 clk = ~clk;
    device_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .dev_req_valid(dev_req_valid), .dev_req_wen(dev_req_wen), .dev_req_addr(dev_req_addr),
        .dev_req_wdata(dev_req_wdata), .dev_req_wmask(dev_req_wmask), .dev_resp_rdata(dev_resp_rdata)
    );
    // Device returns all-ones on writes so a zero write response proves the arbiter masks it.
    always @(posedge clk) if (dev_req_valid) dev_resp_rdata <= dev_req_wen ? '1 : dev_val;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #2;
    endtask
    initial begin
        #50000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        req_valid = '0;
        resp_ready = '1;
        req_wen = '0;
        req_addr = '0;
        req_wdata = '0;
        req_wmask = '0;
        dev_val = '0;
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_dev_valid", dev_req_valid, 0);
        chk("rst_dev_addr", dev_req_addr, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        #10 reset = 1'b0;
        tick;
        req_addr[0*AW +: AW] = 32'h4000_0010;
        dev_val = 32'hDEAD_BEEF;
        req_valid = 4'b0001;
        #1 chk("rd_ready", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        #1 chk("rd_issue_valid", dev_req_valid, 1);
        chk("rd_issue_addr", dev_req_addr, 32'h4000_0010);
        chk("rd_issue_wen", dev_req_wen, 0);
        chk("rd_issue_ready", req_ready, 0);
        tick;
        chk("rd_cap_valid", dev_req_valid, 0);
        chk("rd_cap_resp", resp_valid, 0);
        tick;
        chk("rd_resp_valid", resp_valid, 4'b0001);
        chk("rd_resp_data", resp_rdata, 32'hDEAD_BEEF);
        tick;
        chk("rd_done", resp_valid, 0);
        req_wen[2] = 1'b1;
        req_addr[2*AW +: AW] = 32'h4000_0004;
        req_wdata[2*DW +: DW] = 32'h1234_5678;
        req_wmask[2*MW +: MW] = 4'b0011;
        req_valid = 4'b0100;
        #1 chk("wr_ready", req_ready, 4'b0100);
        tick;
        req_valid = '0;
        #1 chk("wr_issue_valid", dev_req_valid, 1);
        chk("wr_issue_wen", dev_req_wen, 1);
        chk("wr_issue_addr", dev_req_addr, 32'h4000_0004);
        chk("wr_issue_wdata", dev_req_wdata, 32'h1234_5678);
        chk("wr_issue_wmask", dev_req_wmask, 4'b0011);
        tick;
        chk("wr_cap_valid", dev_req_valid, 0);
        tick;
        chk("wr_resp_valid", resp_valid, 4'b0100);
        chk("wr_resp_data", resp_rdata, 0);
        tick;
        req_wen = '0;
        resp_ready = '0;
        dev_val = 32'hCAFE_F00D;
        req_valid = 4'b0010;
        #1 chk("bp_ready", req_ready, 4'b0010);
        tick;
        req_valid = '0;
        tick;
        tick;
        req_valid = 4'b0001;
        resp_ready = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_hold_valid", resp_valid, 4'b0010);
            chk("bp_hold_data", resp_rdata, 32'hCAFE_F00D);
            chk("bp_hold_ready", req_ready, 0);
            tick;
        end
        resp_ready = '1;
        tick;
        #1 chk("bp_after_resp", resp_valid, 0);
        chk("bp_after_ready", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        tick;
        reset = 1'b1;
        req_valid = 4'b1000;
        #1 chk("mid_rst_dev_valid", dev_req_valid, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_addr", dev_req_addr, 0);
        chk("mid_rst_rdata", resp_rdata, 0);
        tick;
        reset = 1'b0;
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("post_rst_resp", resp_valid, 0);
            chk("post_rst_dev", dev_req_valid, 0);
            tick;
        end
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = 32'h1000_0000 + 32'(i * 16);
`ifdef DEVICE_ARB_FIXED_PRIO_EN
        req_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            #1 chk("fp_ready", req_ready, 4'b0001);
            tick;
            #1 chk("fp_addr", dev_req_addr, 32'h1000_0000);
            tick;
            tick;
            chk("fp_resp", resp_valid, 4'b0001);
            tick;
        end
`else
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_ready", req_ready, 64'(1) << (k % N));
            tick;
            #1 chk("rr_busy_ready", req_ready, 0);
            chk("rr_addr", dev_req_addr, 32'h1000_0000 + 32'((k % N) * 16));
            tick;
            tick;
            chk("rr_resp", resp_valid, 64'(1) << (k % N));
            tick;
        end
`endif
        req_valid = '0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/device_req_arbiter.md
Name: device_req_arbiter

Overview:
Shares the single simulated-device DPI port (valid/wen/addr/wdata/wmask in, rdata back) between NUM_REQ requesters in the simulation top.
- Round-robin grant; one outstanding transaction at a time.
- Registered issue and response capture; valid/ready handshake on both request and response sides.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 32, device address width
DATA_W, 32, device data width; wmask width is DATA_W/8

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit set
req_wen  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
req_wmask  in  NUM_REQ*DATA_W/8  packed byte masks
resp_valid  out  NUM_REQ  per-requester response valid; at most one bit set
resp_ready  in  NUM_REQ  per-requester response accept
resp_rdata  out  DATA_W  shared response data; meaningful only with a resp_valid bit set
dev_req_valid  out  1  to device port
dev_req_wen  out  1  to device port
dev_req_addr  out  ADDR_W  to device port
dev_req_wdata  out  DATA_W  to device port
dev_req_wmask  out  DATA_W/8  to device port
dev_resp_rdata  in  DATA_W  from device port; updated at the clk edge that samples dev_req_valid=1

Behaviour:
- Reset (async, any state):
  - state=IDLE, rr_ptr=0.
  - All req_ready, resp_valid and dev_req_valid = 0.
  - dev_req_*, resp_rdata and latched request = 0.
  - Any in-flight transaction is dropped; no response is ever produced for it.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - grant = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready = onehot(grant), combinational, only in IDLE. It depends on req_valid; req_valid must never depend on req_ready.
  - On handshake: latch wen/addr/wdata/wmask and owner, then go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE (1 cycle):
  - dev_req_valid=1; dev_req_* driven from latched registers.
  - Next state CAPTURE.
  - dev_req_valid is 0 in every other state.
- CAPTURE (1 cycle):
  - rdata_q <= dev_req_wen_latched ? 0 : dev_resp_rdata.
  - Next state RESP.
- RESP:
  - resp_valid[owner]=1; resp_rdata=rdata_q, held stable until resp_ready[owner].
  - On handshake: rr_ptr <= (owner+1) mod NUM_REQ, then IDLE.
  - resp_ready of non-owners is ignored.
- Latency: request handshake at cycle T → dev_req_valid at T+1 → resp_valid from T+3. Back-to-back throughput is one transaction per 4 cycles minimum.
- Writes also complete through RESP, with resp_rdata=0.
- Requests arriving while not in IDLE wait with req_ready=0. Requesters must hold valid and payload stable until ready.
- A req_valid dropping before handshake is legal; it is simply not granted.
- Wrap-around: rr_ptr = NUM_REQ-1 followed by a grant to that requester gives rr_ptr 0.
- Simultaneous requests from all requesters: each served exactly once per NUM_REQ grants.

Optional Feature:
DEVICE_ARB_FIXED_PRIO_EN
- Defined: grant = lowest index with req_valid set; rr_ptr is neither used nor updated (held at 0).
- Undefined: round-robin as above.
- Handshake and latency are identical in both modes.

Decomposition:
- Package device_arb_pkg:
  - state enum (IDLE, ISSUE, CAPTURE, RESP) as 2-bit logic.
  - Localparams for default widths.
  - Helper function for the mask width.
- One sub-module, device_rr_picker: purely combinational. Inputs req vector and ptr; outputs onehot grant, grant index and any_valid. Instantiated once in the IDLE grant path.

Test Plan:
- Single read: req0 addr=0x4000_0010 at T; device returns 0xDEAD_BEEF → dev_req_valid only at T+1, resp_valid[0] at T+3, resp_rdata=0xDEAD_BEEF.
- Single write: req2 wen=1, addr=0x4000_0004, wdata=0x1234_5678, wmask=4'b0011 → device sees exactly these values for one cycle; resp_valid[2] with resp_rdata=0.
- Contention: all 4 req_valid held from reset → grant order 0,1,2,3,0; req_ready never has more than one bit set.
- Response backpressure: resp_ready[1] held low for 5 cycles → resp_valid[1] and resp_rdata stable throughout; no new req_ready during those cycles; IDLE on the cycle after acceptance.
- Reset in CAPTURE: assert reset → all outputs 0 immediately; after release, no resp_valid for the dropped transaction and the next grant goes to requester 0.
- With DEVICE_ARB_FIXED_PRIO_EN: req0 and req3 continuously valid → req0 granted every time and req3 starves.
